adpcm_main_udiv_24ns_10ns_15_seq: RTL and testbench

Iterative unsigned restoring divider, the inverse counterpart of the ADPCM datapath's pipelined unsigned multipliers. It recovers a quotient and remainder from a wide product-domain dividend and a narrow divisor. It produces one quotient bit per enabled cycle and uses a start/done handshake. It is gated by the same `ce` clock-enable used by the multiplier cores, so the HLS scheduler can stall it.

---
 rtl/adpcm_div_pkg.sv | 24 ++
 rtl/adpcm_udiv_step.sv | 27 ++
 rtl/adpcm_main_udiv_24ns_10ns_15_seq.sv | 147 ++++++++++++++
 tb/tb_adpcm_main_udiv_24ns_10ns_15_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_div_pkg.sv
// Shared definitions for the iterative unsigned divider.
//   - div_state_e : controller states (IDLE, CALC, DONE)
//   - *_DEF       : default operand / result widths
//   - cnt_width() : iteration counter width for a given dividend width
package adpcm_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIN0_WIDTH_DEF = 24;
  localparam int DIN1_WIDTH_DEF = 10;
  localparam int DOUT_WIDTH_DEF = 15;

  // The counter must hold the value din0_WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_WIDTH_DEF = cnt_width(DIN0_WIDTH_DEF);

endpackage

// File: rtl/adpcm_udiv_step.sv
// One combinational restoring-division step.
//   rem_in   : partial remainder (W+1 bits)
//   bit_in   : next dividend bit, shifted into the remainder LSB
//   divisor  : W-bit divisor
//   rem_out  : updated partial remainder
//   q_out    : resulting quotient bit
module adpcm_udiv_step #(
  parameter int W = 10
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_out
);

  logic [W+1:0] shifted;

  // The full shifted value is kept for the borrow test so that a set MSB
  // (only reachable with a zero divisor) never produces a false borrow.
  assign shifted = {rem_in, bit_in};
  assign q_out   = (shifted >= {2'b00, divisor});
  // The MSB of the shifted value is dropped on restore, which is what makes a
  // zero divisor leave the low dividend bits in the remainder.
  assign rem_out = q_out ? (shifted[W:0] - {1'b0, divisor}) : shifted[W:0];

endmodule

// File: rtl/adpcm_main_udiv_24ns_10ns_15_seq.sv
// Iterative unsigned restoring divider with start/done handshake and ce stall.
// One quotient bit is resolved per enabled cycle.
//   clk, reset  : clock, synchronous active-high reset
//   ce          : clock enable, freezes all state when low
//   start/ready : request / acceptance (accepted in IDLE or DONE)
//   din0, din1  : dividend and divisor, captured on accept
//   dout, rem   : truncated quotient and remainder, held until next completion
//   done        : one enabled-cycle pulse when results update
//   ovf         : full quotient did not fit in dout
//   div_by_zero : captured divisor was zero
// Optional build macro ADPCM_UDIV_ZERO_BYPASS_EN: a zero divisor finishes
// immediately after accept instead of running the full iteration count.
module adpcm_main_udiv_24ns_10ns_15_seq
  import adpcm_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = DOUT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  output logic                  ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  done,
  output logic                  ovf,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(din0_WIDTH);

  div_state_e              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after the last step this register holds the full quotient.
  logic [din0_WIDTH-1:0]   work_reg;
  logic [din1_WIDTH-1:0]   divisor_reg;
  logic [din1_WIDTH:0]     prem_reg;
  logic [dout_WIDTH-1:0]   dout_reg;
  logic [din1_WIDTH-1:0]   rem_reg;
  logic                    ovf_reg;
  logic                    dbz_reg;

  logic                    accept;
  logic                    last_step;
  logic                    bypass;
  logic [din1_WIDTH:0]     step_rem;
  logic                    step_q;
  logic [din0_WIDTH-1:0]   work_next;

`ifdef ADPCM_UDIV_ZERO_BYPASS_EN
  assign bypass = (din1 == '0);
`else
  assign bypass = 1'b0;
`endif

  adpcm_udiv_step #(.W(din1_WIDTH)) u_step (
    .rem_in  (prem_reg),
    .bit_in  (work_reg[din0_WIDTH-1]),
    .divisor (divisor_reg),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  assign work_next = {work_reg[din0_WIDTH-2:0], step_q};

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_reg == CNT_W'(1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = bypass ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      prem_reg    <= '0;
      dout_reg    <= '0;
      rem_reg     <= '0;
      ovf_reg     <= 1'b0;
      dbz_reg     <= 1'b0;
    end else if (ce) begin
      state_reg <= state_next;
      if (accept) begin
        work_reg    <= din0;
        divisor_reg <= din1;
        prem_reg    <= '0;
        cnt_reg     <= CNT_W'(din0_WIDTH);
        if (bypass) begin
          // Same values the full iteration would produce for a zero divisor.
          dout_reg <= '1;
          rem_reg  <= din0[din1_WIDTH-1:0];
          ovf_reg  <= 1'b1;
          dbz_reg  <= 1'b1;
        end
      end else if (state_reg == CALC) begin
        work_reg <= work_next;
        prem_reg <= step_rem;
        cnt_reg  <= cnt_reg - CNT_W'(1);
        if (last_step) begin
          dout_reg <= work_next[dout_WIDTH-1:0];
          rem_reg  <= step_rem[din1_WIDTH-1:0];
          ovf_reg  <= |work_next[din0_WIDTH-1:dout_WIDTH];
          dbz_reg  <= (divisor_reg == '0);
        end
      end
    end
  end

  assign ready       = (state_reg != CALC);
  assign done        = (state_reg == DONE);
  assign dout        = dout_reg;
  assign rem         = rem_reg;
  assign ovf         = ovf_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_adpcm_main_udiv_24ns_10ns_15_seq.sv
// Self-checking bench for the iterative divider: a transaction-level model
// (quotient/remainder by plain arithmetic, completion after 24 enabled
// cycles) is compared against the DUT on every cycle, plus directed cases
// with hand-computed results and latencies.
module tb_adpcm_main_udiv_24ns_10ns_15_seq;

  localparam bit BYP =
`ifdef ADPCM_UDIV_ZERO_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [23:0] din0 = '0;
  logic [9:0]  din1 = '0;
  logic [14:0] dout;
  logic [9:0]  rem;
  logic        done;
  logic        ovf;
  logic        div_by_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit chk_en = 1'b0;

  // Model state
  int          m_left = 0;
  logic        m_done;
  logic [23:0] m_q;
  logic [9:0]  m_r;
  logic        m_z;
  logic [23:0] p_q;
  logic [9:0]  p_r;
  logic        p_z;

  adpcm_main_udiv_24ns_10ns_15_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .ready(ready),
    .din0(din0), .din1(din1), .dout(dout), .rem(rem), .done(done),
    .ovf(ovf), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] ref_q(input logic [23:0] a, input logic [9:0] b);
    if (b == 0) return 24'hFFFFFF;
    return a / {14'd0, b};
  endfunction

  function automatic logic [9:0] ref_r(input logic [23:0] a, input logic [9:0] b);
    logic [23:0] r;
    if (b == 0) r = a;
    else r = a % {14'd0, b};
    return r[9:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: a job finishes after 24 enabled cycles
  // (or immediately on zero divisor when bypass is built in).
  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_z    <= 1'b0;
    end else if (ce) begin
      if (m_left != 0) begin
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
        if (m_left == 1) begin
          m_q <= p_q;
          m_r <= p_r;
          m_z <= p_z;
        end
      end else begin
        m_done <= 1'b0;
        if (start) begin
          p_q <= ref_q(din0, din1);
          p_r <= ref_r(din0, din1);
          p_z <= (din1 == 0);
          if (BYP && din1 == 0) begin
            m_q    <= ref_q(din0, din1);
            m_r    <= ref_r(din0, din1);
            m_z    <= 1'b1;
            m_done <= 1'b1;
          end else begin
            m_left <= 24;
          end
        end
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, m_left == 0);
      chk("done", done, m_done);
      chk("dout", dout, m_q[14:0]);
      chk("rem", rem, m_r);
      chk("ovf", ovf, m_q[23:15] != 0);
      chk("div_by_zero", div_by_zero, m_z);
    end
  end

  task automatic op(input logic [23:0] a, input logic [9:0] b);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    din0  = a;
    din1  = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
    $display("op: accepted din0=%0d din1=%0d at cycle %0d", a, b, acc_cyc);
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 200);
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done never rose, expected latency %0d", name, exp_lat);
    end else begin
      chk({name, "_latency"}, cyc - acc_cyc + 1, exp_lat);
      $display("%s: done dout=%0h rem=%0d ovf=%0b dbz=%0b latency=%0d",
               name, dout, rem, ovf, div_by_zero, cyc - acc_cyc + 1);
    end
  endtask

  initial begin
    int r;
    int pulses;

    // Reset state
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rem", rem, 0);
    chk("rst_flags", {ovf, div_by_zero}, 0);
    reset = 1'b0;

    // 1: basic division
    op(24'd1000, 10'd7);
    wait_done("t1", 25);
    chk("t1_dout", dout, 142);
    chk("t1_rem", rem, 6);
    chk("t1_flags", {ovf, div_by_zero}, 2'b00);

    // 2: divide by zero
    op(24'd1234, 10'd0);
    wait_done("t2", BYP ? 1 : 25);
    chk("t2_dout", dout, 15'h7FFF);
    chk("t2_rem", rem, 210);
    chk("t2_flags", {ovf, div_by_zero}, 2'b11);

    // 3: maximum dividend, unit divisor
    op(24'hFFFFFF, 10'd1);
    wait_done("t3", 25);
    chk("t3_dout", dout, 15'h7FFF);
    chk("t3_rem", rem, 0);
    chk("t3_flags", {ovf, div_by_zero}, 2'b10);

    // 4: five-cycle ce stall mid-CALC
    op(24'd500, 10'd9);
    repeat (10) @(negedge clk);
    ce = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_dout", dout, 15'h7FFF);
      chk("t4_stall_rem", rem, 0);
      chk("t4_stall_ready", ready, 0);
    end
    ce = 1'b1;
    wait_done("t4", 30);
    chk("t4_dout", dout, 55);
    chk("t4_rem", rem, 5);

    // 5a: start during CALC is ignored
    op(24'd200, 10'd3);
    repeat (5) @(negedge clk);
    chk("t5_busy_ready", ready, 0);
    start = 1'b1;
    din0  = 24'd999;
    din1  = 10'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5", 25);
    chk("t5_dout", dout, 66);
    chk("t5_rem", rem, 2);

    // 5b: reset mid-CALC aborts with no done
    op(24'd777, 10'd5);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_rst_ready", ready, 1);
    chk("t5_rst_dout", dout, 0);
    chk("t5_rst_rem", rem, 0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("t5_rst_no_done", pulses, 0);
    $display("t5: reset abort checked");

    // 6: back-to-back start in the DONE cycle
    op(24'd1000, 10'd7);
    wait_done("t6a", 25);
    start = 1'b1;
    din0  = 24'd100;
    din1  = 10'd10;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
    $display("op: back-to-back accepted at cycle %0d", acc_cyc);
    repeat (23) begin
      @(negedge clk);
      chk("t6_hold_dout", dout, 142);
    end
    wait_done("t6b", 25);
    chk("t6_dout", dout, 10);
    chk("t6_rem", rem, 0);

    // Randomized traffic: ce stalls, start pulses, zero/small divisors, rare reset.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      ce    = ($urandom_range(0, 4) != 0);
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      din0  = 24'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      din1 = 10'd0;
      else if (r < 4)  din1 = 10'($urandom_range(1, 15));
      else             din1 = 10'($urandom);
      if (done === 1'b1)
        $display("rand: done dout=%0h rem=%0d ovf=%0b dbz=%0b", dout, rem, ovf, div_by_zero);
    end
    ce    = 1'b1;
    start = 1'b0;
    reset = 1'b0;
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
